// File: rtl/logic_unit_pipe_pkg.sv
// rtl/logic_unit_pipe_pkg.sv - op-select width and op codes shared by the logic unit files
package logic_unit_pipe_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_pipe_op_core.sv
// rtl/logic_unit_pipe_op_core.sv - combinational bitwise op with zero/all-ones reduction flags
module logic_op_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDN:  y = a & ~b;
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end

  // For WIDTH=1 the AND-reduction degenerates to y itself.
  assign zero = ~|y;
  assign ones = &y;

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready bitwise logic unit with completion counter
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] done_cnt
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [OP_W-1:0]  r_s1_op;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic             r_s2_zero;
  logic             r_s2_ones;
  logic [CNT_W-1:0] r_cnt;

  logic             w_adv1;
  logic             w_adv2;
  logic [WIDTH-1:0] w_y;
  logic             w_zero;
  logic             w_ones;

  // Each stage moves when it is empty or the stage downstream moves; no skid buffer.
  assign w_adv2 = !r_s2_valid || out_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a    (r_s1_a),
    .b    (r_s1_b),
    .op   (r_s1_op),
    .y    (w_y),
    .zero (w_zero),
    .ones (w_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_ones  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a  <= in_a;
          r_s1_b  <= in_b;
          r_s1_op <= in_op;
        end
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_y    <= w_y;
          r_s2_zero <= w_zero;
          r_s2_ones <= w_ones;
        end
      end
      if (r_s2_valid && out_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_s2_valid;
  assign out_y     = r_s2_y;
  assign out_zero  = r_s2_zero;
  assign out_ones  = r_s2_ones;
  assign done_cnt  = r_cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe against a queue reference model
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_ones;
  logic [CNT_W-1:0] done_cnt;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tx = 0;
  int acc = 0;
  logic [WIDTH-1:0] exp_q[$];
  int acc_cyc_q[$];
  bit lat_chk = 1'b0;
  bit use_tab = 1'b0;
  logic [WIDTH-1:0] drv_exp;
  logic smp_in_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  // One clock: observe handshakes mid-cycle, update the model, check the counter after the edge.
  task automatic step();
    logic acc_now, out_now;
    logic [WIDTH-1:0] e;
    int c;
    @(negedge clk);
    smp_in_ready = in_ready;
    acc_now = !rst && in_valid && in_ready;
    out_now = !rst && out_valid && out_ready;
    if (out_now) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = acc_cyc_q.pop_front();
        chk("out_y", out_y, e);
        chk("out_zero", out_zero, e == '0);
        chk("out_ones", out_ones, e == '1);
        if (lat_chk) chk("latency", cyc - c, 2);
      end
    end
    if (acc_now) begin
      exp_q.push_back(use_tab ? drv_exp : ref_op(in_op, in_a, in_b));
      acc_cyc_q.push_back(cyc);
      acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
      tx = 0;
    end else if (out_now) begin
      tx++;
    end
    chk("done_cnt", done_cnt, tx % 16);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] t1_tab [8];
  int acc0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t1_tab = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; drv_exp = '0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_ones", out_ones, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // T1: op sweep with fixed operands against the tabulated results
    use_tab = 1'b1; lat_chk = 1'b1; out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 3'(op); drv_exp = t1_tab[op];
      step();
      chk("t1_accept", smp_in_ready, 1);
    end
    drain();

    // T2: reduction flags at both extremes
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_op = 3'd2; drv_exp = 8'h00;
    step();
    in_a = 8'h00; in_b = 8'h00; in_op = 3'd4; drv_exp = 8'hFF;
    step();
    drain();
    use_tab = 1'b0;

    // T3: backpressure fills both stages
    lat_chk = 1'b0; out_ready = 1'b0; acc0 = acc;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 8'(1 << k); in_b = 8'(1 << k); in_op = 3'd0;
      step();
    end
    chk("t3_in_ready_full", smp_in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    step();
    chk("t3_frozen_y", out_y, 8'h01);
    chk("t3_accepted_two", acc - acc0, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (smp_in_ready) break;
    end
    drain();
    chk("t3_accepted_three", acc - acc0, 3);

    // T4: 16 back-to-back beats, counter wraps
    do_reset();
    lat_chk = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
      step();
      chk("t4_accept", smp_in_ready, 1);
    end
    drain();
    chk("t4_wrap", done_cnt, 0);
    chk("t4_transfers", tx, 16);

    // T5: reset with two beats in flight and one offered during reset
    lat_chk = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
      step();
    end
    out_ready = 1'b1; in_a = 8'h5A; in_op = 3'd7;
    do_reset();
    in_valid = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h0F; in_op = 3'd6;
    step();
    drain();
    chk("t5_one_done", done_cnt, 1);

    // T6: random valid/ready toggling, data held while stalled
    acc0 = acc; in_valid = 1'b0;
    for (int i = 0; i < 8000 && (acc - acc0) < 1000; i++) begin
      if (!in_valid || smp_in_ready) begin
        in_valid = ($urandom_range(9) < 7) && ((acc - acc0) < 1000);
        in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
      end
      out_ready = $urandom_range(9) < 6;
      step();
      if ((acc - acc0) >= 1000) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    drain();
    chk("t6_beats", acc - acc0, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
